// File: rtl/mem_rotate_pipe.sv
// Rotating crossbar between NrPorts requesters and NrPorts fixed-latency banks.
// Reads are routed back through per-bank tracking pipes. Optional stall counter: MEM_ROTATE_PIPE_STATS_EN.
module mem_rotate_pipe #(
    parameter int unsigned NrPorts       = 8,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned MemoryLatency = 1,
    parameter int unsigned MinShift      = 1,
    localparam int unsigned ShW          = $clog2(NrPorts)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrPorts-1:0]                  in_req_valid_i,
    input  logic [NrPorts-1:0][AddrWidth-1:0]   in_req_addr_i,
    input  logic [NrPorts-1:0]                  in_req_we_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]   in_req_wdata_i,
    output logic [NrPorts-1:0]                  in_req_ready_o,
    output logic [NrPorts-1:0]                  in_rsp_valid_o,
    output logic [NrPorts-1:0][DataWidth-1:0]   in_rsp_rdata_o,
    output logic [NrPorts-1:0]                  out_req_valid_o,
    output logic [NrPorts-1:0][AddrWidth-1:0]   out_req_addr_o,
    output logic [NrPorts-1:0]                  out_req_we_o,
    output logic [NrPorts-1:0][DataWidth-1:0]   out_req_wdata_o,
    input  logic [NrPorts-1:0]                  out_req_gnt_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]   out_rsp_rdata_i,
    input  logic [ShW-1:0]                      shift_i,
    input  logic                                shift_valid_i,
    output logic                                shift_ready_o,
    output logic [ShW-1:0]                      shift_active_o
`ifdef MEM_ROTATE_PIPE_STATS_EN
    ,
    output logic [31:0]                         stall_cnt_o
`endif
);

    localparam logic [ShW-1:0] ShiftMask = ~ShW'(MinShift - 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                                 state;
    logic [ShW-1:0]                         shift_q;
    logic [ShW-1:0]                         s;
    logic [NrPorts-1:0][MemoryLatency-1:0]  trk;
    logic [NrPorts-1:0]                     load;
    logic                                   busy;

    assign s              = shift_q & ShiftMask;
    assign shift_active_o = s;
    assign busy           = |trk;
    assign shift_ready_o  = (state == DRAIN) && !busy;

    // Bank j is fed by requester (j - s); requester i hears back from bank (i + s).
    always_comb begin
        logic [ShW-1:0] src;
        logic [ShW-1:0] dst;
        src             = '0;
        dst             = '0;
        out_req_valid_o = '0;
        out_req_addr_o  = '0;
        out_req_we_o    = '0;
        out_req_wdata_o = '0;
        load            = '0;
        in_req_ready_o  = '0;
        in_rsp_valid_o  = '0;
        in_rsp_rdata_o  = '0;
        for (int j = 0; j < NrPorts; j++) begin
            src                = ShW'(j) - s;
            out_req_valid_o[j] = (state == RUN) && in_req_valid_i[src];
            out_req_addr_o[j]  = in_req_addr_i[src];
            out_req_we_o[j]    = in_req_we_i[src];
            out_req_wdata_o[j] = in_req_wdata_i[src];
            load[j]            = out_req_valid_o[j] && out_req_gnt_i[j] && !out_req_we_o[j];
        end
        for (int i = 0; i < NrPorts; i++) begin
            dst               = ShW'(i) + s;
            in_req_ready_o[i] = (state == RUN) && out_req_gnt_i[dst];
            in_rsp_valid_o[i] = trk[dst][MemoryLatency-1];
            in_rsp_rdata_o[i] = in_rsp_valid_o[i] ? out_rsp_rdata_i[dst] : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trk <= '0;
        end else begin
            for (int j = 0; j < NrPorts; j++) begin
                for (int k = MemoryLatency - 1; k > 0; k--) begin
                    trk[j][k] <= trk[j][k-1];
                end
                trk[j][0] <= load[j];
            end
        end
    end

    // The shift only changes once every tracked read has returned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= RUN;
            shift_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (shift_valid_i) state <= DRAIN;
                end
                DRAIN: begin
                    if (!shift_valid_i) begin
                        state <= RUN;
                    end else if (!busy) begin
                        shift_q <= shift_i;
                        state   <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef MEM_ROTATE_PIPE_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if ((state == DRAIN) && (|in_req_valid_i) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_rotate_pipe.sv
// Bench for mem_rotate_pipe: event-queue reference model, directed table and corner sequences.
module tb_mem_rotate_pipe;

    localparam int NP = 4;
    localparam int ML = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP-1:0]        v_valid;
    logic [NP-1:0][31:0]  v_addr;
    logic [NP-1:0]        v_we;
    logic [NP-1:0][31:0]  v_wdata;
    logic [NP-1:0]        v_gnt;
    logic [NP-1:0][31:0]  v_rdata;
    logic [1:0]           v_shift;
    logic                 v_sv;

    logic [NP-1:0]        req_ready, rsp_valid, oreq_valid, oreq_we;
    logic [NP-1:0][31:0]  rsp_rdata, oreq_addr, oreq_wdata;
    logic                 shift_ready;
    logic [1:0]           shift_active;
`ifdef MEM_ROTATE_PIPE_STATS_EN
    logic [31:0]          stall_cnt;
    logic [31:0]          stall_cnt2;
`endif

    // second instance with coarse shift granularity
    logic [NP-1:0]        w_valid, w_gnt;
    logic [1:0]           w_shift;
    logic                 w_sv;
    logic [NP-1:0]        w_req_ready, w_rsp_valid, w_oreq_valid, w_oreq_we;
    logic [NP-1:0][31:0]  w_rsp_rdata, w_oreq_addr, w_oreq_wdata;
    logic                 w_shift_ready;
    logic [1:0]           w_shift_active;

    always #5 clk = ~clk;

    mem_rotate_pipe #(.NrPorts(NP), .AddrWidth(32), .DataWidth(32), .MemoryLatency(ML), .MinShift(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_req_valid_i(v_valid), .in_req_addr_i(v_addr), .in_req_we_i(v_we), .in_req_wdata_i(v_wdata),
        .in_req_ready_o(req_ready), .in_rsp_valid_o(rsp_valid), .in_rsp_rdata_o(rsp_rdata),
        .out_req_valid_o(oreq_valid), .out_req_addr_o(oreq_addr), .out_req_we_o(oreq_we),
        .out_req_wdata_o(oreq_wdata), .out_req_gnt_i(v_gnt), .out_rsp_rdata_i(v_rdata),
        .shift_i(v_shift), .shift_valid_i(v_sv), .shift_ready_o(shift_ready), .shift_active_o(shift_active)
`ifdef MEM_ROTATE_PIPE_STATS_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    mem_rotate_pipe #(.NrPorts(NP), .AddrWidth(32), .DataWidth(32), .MemoryLatency(ML), .MinShift(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .in_req_valid_i(w_valid), .in_req_addr_i('0), .in_req_we_i('0), .in_req_wdata_i('0),
        .in_req_ready_o(w_req_ready), .in_rsp_valid_o(w_rsp_valid), .in_rsp_rdata_o(w_rsp_rdata),
        .out_req_valid_o(w_oreq_valid), .out_req_addr_o(w_oreq_addr), .out_req_we_o(w_oreq_we),
        .out_req_wdata_o(w_oreq_wdata), .out_req_gnt_i(w_gnt), .out_rsp_rdata_i('0),
        .shift_i(w_shift), .shift_valid_i(w_sv), .shift_ready_o(w_shift_ready), .shift_active_o(w_shift_active)
`ifdef MEM_ROTATE_PIPE_STATS_EN
        , .stall_cnt_o(stall_cnt2)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a read granted in cycle t comes back in cycle t+ML.
    typedef struct { int due; int port; int bank; } ev_t;
    ev_t evq[$];
    int  cyc = 0;
    bit  m_drain = 0;
    int  m_shift = 0;
    int  m_stall = 0;

    task automatic model_reset();
        evq.delete();
        m_drain = 0;
        m_shift = 0;
        m_stall = 0;
    endtask

    task automatic step();
        logic [NP-1:0]       e_rv;
        logic [NP-1:0][31:0] e_rd;
        logic [NP-1:0]       e_ov, e_rdy;
        bit                  busy;
        ev_t                 keep[$];
        if (rst) model_reset();
        @(negedge clk);
        e_rv = '0; e_rd = '0; e_ov = '0; e_rdy = '0; busy = 0;
        foreach (evq[k]) begin
            if (evq[k].due == cyc) begin
                e_rv[evq[k].port] = 1'b1;
                e_rd[evq[k].port] = v_rdata[evq[k].bank];
            end
            if (evq[k].due >= cyc) busy = 1;
        end
        for (int i = 0; i < NP; i++) begin
            int b;
            b = (i + m_shift) % NP;
            if (!m_drain) begin
                e_ov[b]  = v_valid[i];
                e_rdy[i] = v_gnt[b];
            end
        end
        chk("out_req_valid", 64'(oreq_valid), 64'(e_ov));
        chk("in_req_ready", 64'(req_ready), 64'(e_rdy));
        chk("in_rsp_valid", 64'(rsp_valid), 64'(e_rv));
        for (int i = 0; i < NP; i++) begin
            chk("in_rsp_rdata", 64'(rsp_rdata[i]), 64'(e_rd[i]));
            if (e_ov[(i + m_shift) % NP]) begin
                chk("out_req_addr", 64'(oreq_addr[(i + m_shift) % NP]), 64'(v_addr[i]));
                chk("out_req_we", 64'(oreq_we[(i + m_shift) % NP]), 64'(v_we[i]));
                chk("out_req_wdata", 64'(oreq_wdata[(i + m_shift) % NP]), 64'(v_wdata[i]));
            end
        end
        chk("shift_ready", 64'(shift_ready), 64'(m_drain && !busy));
        chk("shift_active", 64'(shift_active), 64'(m_shift));
`ifdef MEM_ROTATE_PIPE_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        @(posedge clk);
        if (!rst) begin
            if (!m_drain) begin
                for (int i = 0; i < NP; i++) begin
                    int b;
                    b = (i + m_shift) % NP;
                    if (v_valid[i] && v_gnt[b] && !v_we[i]) evq.push_back('{cyc + ML, i, b});
                end
                if (v_sv) m_drain = 1;
            end else begin
                if (|v_valid) m_stall++;
                if (!v_sv) m_drain = 0;
                else if (!busy) begin
                    m_shift = int'(v_shift);
                    m_drain = 0;
                end
            end
            foreach (evq[k]) if (evq[k].due > cyc) keep.push_back(evq[k]);
            evq = keep;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        v_valid = '0; v_we = '0; v_gnt = '0; v_sv = 1'b0;
    endtask

    task automatic program_shift(input int sh);
        v_sv = 1'b1;
        v_shift = 2'(sh);
        step();
        for (int k = 0; k < 8 && m_drain; k++) step();
        v_sv = 1'b0;
        if (m_drain) chk("shift_handshake_timeout", 64'd1, 64'd0);
    endtask

    typedef struct { int shift; int port; int bank; } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{0, 2, 2};
        tbl[1] = '{1, 3, 0};
        tbl[2] = '{2, 1, 3};
        tbl[3] = '{3, 0, 3};
        tbl[4] = '{1, 0, 1};

        rst = 1'b1; idle(); v_addr = '0; v_wdata = '0; v_rdata = '0; v_shift = '0;
        w_valid = '0; w_gnt = '0; w_shift = '0; w_sv = 1'b0;
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_shift_ready", 64'(shift_ready), 64'd0);
        chk("reset_shift_active", 64'(shift_active), 64'd0);
        chk("reset_out_req_valid", 64'(oreq_valid), 64'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Directed routing table
        foreach (tbl[n]) begin
            idle(); step(); step();
            program_shift(tbl[n].shift);
            chk("tbl_shift_active", 64'(shift_active), 64'(tbl[n].shift));
            v_valid = '0; v_valid[tbl[n].port] = 1'b1; v_we = '0; v_gnt = '1;
            v_addr[tbl[n].port] = 32'h10;
            #1;
            chk("tbl_route", 64'(oreq_valid), 64'(1) << tbl[n].bank);
            step();
            idle(); step();
            v_rdata = '0; v_rdata[tbl[n].bank] = 32'hCAFE;
            #1;
            chk("tbl_rsp_valid", 64'(rsp_valid), 64'(1) << tbl[n].port);
            chk("tbl_rsp_rdata", 64'(rsp_rdata[tbl[n].port]), 64'hCAFE);
            step();
        end

        // Two reads in flight while a shift to 2 is requested
        idle(); step(); step();
        program_shift(0);
        v_valid = 4'b0001; v_we = '0; v_gnt = '1;
        step();
        v_valid = 4'b0010; v_sv = 1'b1; v_shift = 2'd2;
        step();
        v_valid = 4'b1111;
        #1;
        chk("drain_ready_a", 64'(shift_ready), 64'd0);
        chk("drain_in_req_ready_a", 64'(req_ready), 64'd0);
        chk("drain_out_valid_a", 64'(oreq_valid), 64'd0);
        step();
        #1;
        chk("drain_ready_b", 64'(shift_ready), 64'd0);
        chk("drain_in_req_ready_b", 64'(req_ready), 64'd0);
        step();
        #1;
        chk("drain_ready_c", 64'(shift_ready), 64'd1);
        step();
        v_sv = 1'b0;
        chk("drain_shift_active", 64'(shift_active), 64'd2);
`ifdef MEM_ROTATE_PIPE_STATS_EN
        chk("drain_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        idle(); step();

        // Shift request withdrawn during DRAIN keeps the old shift
        v_valid = 4'b0100; v_gnt = '1;
        step();
        v_sv = 1'b1; v_shift = 2'd1; v_valid = '0;
        step();
        v_sv = 1'b0;
        step(); step(); step();
        chk("withdraw_shift_active", 64'(shift_active), 64'd2);

        // Write produces no response
        idle(); program_shift(0);
        v_valid = 4'b0001; v_we = 4'b0001; v_gnt = '1;
        step();
        idle(); step();
        #1;
        chk("write_no_rsp", 64'(rsp_valid), 64'd0);
        step();

        // Reset while a read is in flight
        v_valid = 4'b0010; v_gnt = '1;
        step();
        idle(); rst = 1'b1;
        step();
        rst = 1'b0;
        v_rdata = '1;
        #1;
        chk("reset_discard_rsp", 64'(rsp_valid), 64'd0);
        step(); step();

        // MinShift=2 instance: shift 3 masks to 2, port 1 hits bank 3
        w_sv = 1'b1; w_shift = 2'd3;
        step();
        #1;
        chk("min_shift_ready", 64'(w_shift_ready), 64'd1);
        step();
        w_sv = 1'b0;
        chk("min_shift_active", 64'(w_shift_active), 64'd2);
        w_valid = 4'b0010; w_gnt = '1;
        #1;
        chk("min_shift_route", 64'(w_oreq_valid), 64'b1000);
        chk("min_shift_ready_map", 64'(w_req_ready), 64'b1111);
        w_valid = '0; w_gnt = '0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            v_valid = 4'($urandom);
            v_we    = 4'($urandom);
            v_gnt   = 4'($urandom);
            for (int i = 0; i < NP; i++) begin
                v_addr[i]  = $urandom;
                v_wdata[i] = $urandom;
                v_rdata[i] = $urandom;
            end
            if (!v_sv && $urandom_range(0, 9) == 0) begin
                v_sv = 1'b1;
                v_shift = 2'($urandom);
            end else if (v_sv && ($urandom_range(0, 7) == 0 || (m_drain && $urandom_range(0, 3) == 0))) begin
                v_sv = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
